codifica_latencia: RTL

- Encoder counterpart of the bucket-index-to-latency decoder.
- Accepts a raw latency delta, finds its most-significant set bit with a sequential MSB-down scan, and emits the one-hot bucket index that the decoder consumes, plus the matching latency code.
- Sits between the timestamp-difference logic and the bucket/histogram update path.
- Uses a valid/ready handshake on both sides and keeps saturating statistics counters.

---
 rtl/codifica_latencia_if.sv | 26 ++
 rtl/codifica_latencia.sv | 118 +++++++++++
 2 files changed

// File: rtl/codifica_latencia_if.sv
// Handshake bundle for the latency encoder.
// The upstream/downstream side uses master; the encoder uses slave.
interface codifica_latencia_if #(
  parameter int INDEX_WIDTH = 14,
  parameter int BITS_SHIFT  = 7,
  parameter int DELTA_WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DELTA_WIDTH-1:0] delta;
  logic                   out_valid;
  logic                   out_ready;
  logic [INDEX_WIDTH-1:0] index;
  logic [BITS_SHIFT-1:0]  latencia;
  logic                   clamped;

  modport master (
    output in_valid, delta, out_ready,
    input  in_ready, out_valid, index, latencia, clamped
  );

  modport slave (
    input  in_valid, delta, out_ready,
    output in_ready, out_valid, index, latencia, clamped
  );
endinterface

// File: rtl/codifica_latencia.sv
// Latency delta encoder: MSB-down scan to a one-hot bucket index
// and latency code, with saturating sample/clamp counters.
module codifica_latencia #(
  parameter int INDEX_WIDTH = 14,
  parameter int BITS_SHIFT  = 7,
  parameter int DELTA_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  codifica_latencia_if.slave   bus,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] clamp_count
);

  localparam int PW = $clog2(DELTA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } state_t;

  state_t state, nxt;

  logic [DELTA_WIDTH-1:0] delta_q;
  logic [PW-1:0]          ptr;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [BITS_SHIFT-1:0]  lat_q;
  logic                   clamp_q;

  logic                   accept;
  logic                   fire;
  logic                   hit;
  logic                   last;
  logic                   clamp_hit;
  logic [PW-1:0]          b;
  logic [INDEX_WIDTH-1:0] onehot;
  logic [BITS_SHIFT-1:0]  code;

  assign accept = bus.in_valid && bus.in_ready;
  assign fire   = bus.out_valid && bus.out_ready;
  assign hit    = delta_q[ptr];
  assign last   = (ptr == '0);

  // Bits above the top bucket all fold into it.
  assign clamp_hit = int'(ptr) >= INDEX_WIDTH;
  assign b         = clamp_hit ? PW'(INDEX_WIDTH - 1) : ptr;
  assign onehot    = {{(INDEX_WIDTH-1){1'b0}}, 1'b1} << b;
  assign code      = BITS_SHIFT'(INDEX_WIDTH - 1)
                   - BITS_SHIFT'(b);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = SCAN;
      SCAN: if (hit || last) nxt = OUT;
      OUT:  if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: bus.in_ready  = 1'b1;
      OUT:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delta_q      <= '0;
      ptr          <= '0;
      index_q      <= '0;
      lat_q        <= '1;
      clamp_q      <= 1'b0;
      sample_count <= '0;
      clamp_count  <= '0;
    end else begin
      if (accept) begin
        delta_q <= bus.delta;
        ptr     <= PW'(DELTA_WIDTH - 1);
      end
      if (state == SCAN) begin
        if (hit) begin
          index_q <= onehot;
          lat_q   <= code;
          clamp_q <= clamp_hit;
        end else if (last) begin
          index_q <= '0;
          lat_q   <= '1;
          clamp_q <= 1'b0;
        end else begin
          ptr <= ptr - 1'b1;
        end
      end
      if (fire) begin
        if (sample_count != '1)
          sample_count <= sample_count + 1'b1;
        if (clamp_q && (clamp_count != '1))
          clamp_count <= clamp_count + 1'b1;
      end
    end
  end

  assign bus.index    = index_q;
  assign bus.latencia = lat_q;
  assign bus.clamped  = clamp_q;

endmodule
